multi_dice_roll: RTL and testbench
==================================

Name: multi_dice_roll

Overview:
Parametrised successor to the single-die electronic dice. It rolls NUM_DICE independent dice with FACES faces each. Dice advance while button is held; on release they freeze, the total is registered, and a one-cycle done pulse is raised. Per-die hold lets the user keep selected dice between rolls. A wrapping roll counter is provided. Sits between the debounced button input and the display/score logic.

Parameters:
NUM_DICE, 2, number of dice (1..8)
FACES, 6, faces per die (2..15); legal face values 1..FACES
ROLL_CNT_W, 8, width of completed-roll counter
FACE_W (localparam), $clog2(FACES+1), bits per die
SUM_W (localparam), $clog2(NUM_DICE*FACES+1), bits of total

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
button  in  1  roll request; dice advance while high
hold  in  NUM_DICE  per-die hold; bit k=1 freezes die k
throw  out  NUM_DICE*FACE_W  packed face values, die k at [k*FACE_W +: FACE_W]
sum  out  SUM_W  registered total of last completed roll
done  out  1  one-cycle pulse, roll completed
rolling  out  1  high while state is ROLLING
roll_cnt  out  ROLL_CNT_W  completed rolls, wraps at 2^ROLL_CNT_W
doubles  out  1  present only with DOUBLES_EN

Behaviour:
- Reset (rst=0 at an edge): every die=1, sum=NUM_DICE, done=0, roll_cnt=0, doubles=0, state=IDLE. Reset overrides all else, including mid-roll.
- States: IDLE, ROLLING, SUM.
- IDLE: button=1 -> ROLLING; the dice advance on that same edge.
- ROLLING: dice advance on every edge with button=1; button=0 -> SUM with dice frozen.
- SUM: one cycle, button ignored. Edge registers sum=total of all dice (zero-extended to SUM_W), done=1, roll_cnt+1, then returns to IDLE.
- done is high for exactly one cycle, asserted 2 edges after the first edge that samples button=0.
- Advance rule is an odometer in die index order:
  - carry_in(0)=1.
  - A non-held die with carry_in=1 increments; from FACES it wraps to 1 and carry_out=1, otherwise carry_out=0.
  - A held die keeps its value and passes carry_in straight to carry_out.
- hold changes take effect on the next advance edge. With all dice held, a roll still completes normally with values unchanged.
- Invariant: each die is always in 1..FACES. 0 or values >FACES are never output.
- rolling is a registered decode of state==ROLLING.
- roll_cnt wraps from all-ones to 0 without a flag.

Optional Feature:
DOUBLES_EN.
- Defined: doubles port exists. It is updated on the SUM edge together with sum: 1 if all dice are equal (NUM_DICE>=2), 0 if NUM_DICE=1. It holds until the next SUM edge or reset. Reset value 0.
- Undefined: doubles port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use NUM_DICE=2, FACES=6.
- Reset: rst=0 for 2 cycles -> throw={3'd1,3'd1}, sum=2, done=0, roll_cnt=0, rolling=0.
- Short roll: button=1 for 4 edges then 0 -> die0=5, die1=1; done pulses 1 cycle, 2 edges after release; sum=6, roll_cnt=1.
- Carry/wrap: button=1 for 6 edges -> die0 wraps 6->1 and die1=2; sum=3; die never reads 0 or 7 (checker on every cycle).
- Hold: hold=2'b01 from die0=3, then button=1 for 8 edges -> die0 stays 3; die1 advances 1->3 after wrapping through 6 (8 steps); sum=6.
- Reset mid-roll: rst=0 while rolling=1 -> next edge dice=1, state IDLE, no done pulse, roll_cnt unchanged.
- DOUBLES_EN: roll to die0=2, die1=2 -> doubles=1 on the done cycle; next roll to {1,3} -> doubles=0.

Source files
------------

// File: rtl/multi_dice_roll.sv
// NUM_DICE odometer-style dice with per-die hold, registered total and roll counter.
// Optional all-dice-equal flag on `doubles` when DOUBLES_EN is defined.
module multi_dice_roll #(
  parameter  int NUM_DICE   = 2,
  parameter  int FACES      = 6,
  parameter  int ROLL_CNT_W = 8,
  localparam int FACE_W     = $clog2(FACES + 1),
  localparam int SUM_W      = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       button,
  input  logic [NUM_DICE-1:0]        hold,
  output logic [NUM_DICE*FACE_W-1:0] throw,
  output logic [SUM_W-1:0]           sum,
  output logic                       done,
  output logic                       rolling,
  output logic [ROLL_CNT_W-1:0]      roll_cnt
`ifdef DOUBLES_EN
  ,
  output logic                       doubles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLLING,
    S_SUM
  } state_t;

  localparam logic [FACE_W-1:0] FACE_MAX = FACE_W'(FACES);
  localparam logic [FACE_W-1:0] FACE_ONE = FACE_W'(1);

  state_t                  state_q, state_d;
  logic [FACE_W-1:0]       dice_q [NUM_DICE];
  logic [FACE_W-1:0]       dice_d [NUM_DICE];
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [ROLL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    rolling_q, rolling_d;
  logic                    advance;
  logic                    carry;
  logic [SUM_W-1:0]        total;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (button) begin
          state_d = S_ROLLING;
          advance = 1'b1;
        end
      end
      S_ROLLING: begin
        if (button) advance = 1'b1;
        else        state_d = S_SUM;
      end
      S_SUM:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Held dice are transparent to the carry chain.
  always_comb begin
    carry = 1'b1;
    for (int k = 0; k < NUM_DICE; k++) begin
      dice_d[k] = dice_q[k];
      if (!hold[k] && carry) begin
        if (dice_q[k] >= FACE_MAX || dice_q[k] == '0) begin
          dice_d[k] = FACE_ONE;
        end else begin
          dice_d[k] = dice_q[k] + FACE_ONE;
          carry     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    total = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      total = total + SUM_W'(dice_q[k]);
    end
  end

  always_comb begin
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rolling_d = (state_d == S_ROLLING);
    if (state_q == S_SUM) begin
      sum_d  = total;
      cnt_d  = cnt_q + 1'b1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sum_q     <= SUM_W'(NUM_DICE);
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rolling_q <= 1'b0;
      for (int k = 0; k < NUM_DICE; k++) begin
        dice_q[k] <= FACE_ONE;
      end
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rolling_q <= rolling_d;
      if (advance) begin
        for (int k = 0; k < NUM_DICE; k++) begin
          dice_q[k] <= dice_d[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DICE; g++) begin : g_throw
    assign throw[g*FACE_W +: FACE_W] = dice_q[g];
  end

  assign sum      = sum_q;
  assign done     = done_q;
  assign rolling  = rolling_q;
  assign roll_cnt = cnt_q;

`ifdef DOUBLES_EN
  logic all_eq;
  logic doubles_q, doubles_d;

  always_comb begin
    all_eq = (NUM_DICE >= 2);
    for (int k = 1; k < NUM_DICE; k++) begin
      if (dice_q[k] != dice_q[0]) all_eq = 1'b0;
    end
  end

  always_comb begin
    doubles_d = doubles_q;
    if (state_q == S_SUM) doubles_d = all_eq;
  end

  always_ff @(posedge clk) begin
    if (!rst) doubles_q <= 1'b0;
    else      doubles_q <= doubles_d;
  end

  assign doubles = doubles_q;
`endif

endmodule

// File: tb/tb_multi_dice_roll.sv
// Directed bench for multi_dice_roll (NUM_DICE=2, FACES=6) with a result scoreboard.
// Build with DOUBLES_EN defined to also exercise the doubles flag.
module tb_multi_dice_roll;

  localparam int ND = 2;
  localparam int FC = 6;
  localparam int FW = 3;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          button;
  logic [ND-1:0] hold;
  logic [ND*FW-1:0] throw;
  logic [SW-1:0] sum;
  logic          done;
  logic          rolling;
  logic [7:0]    roll_cnt;
`ifdef DOUBLES_EN
  logic          doubles;
`endif

  typedef struct {
    int d0;
    int d1;
    int s;
    int cnt;
    int dbl;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] cnt_m = '0;
  int   v_m = 0;

  multi_dice_roll #(
    .NUM_DICE(ND),
    .FACES(FC),
    .ROLL_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .hold(hold),
    .throw(throw),
    .sum(sum),
    .done(done),
    .rolling(rolling),
    .roll_cnt(roll_cnt)
`ifdef DOUBLES_EN
    ,
    .doubles(doubles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < ND; k++) begin
        chk("die_range", 32'((throw[k*FW +: FW] >= 1) &&
                             (throw[k*FW +: FW] <= FC)), 1);
      end
    end
  end

  // Roll for n button-high edges; caller gives the dice it expects.
  task automatic roll(input int n, input int e0, input int e1);
    exp_t e;
    exp_t g;
    int   lat;
    button = 1'b1;
    repeat (n) @(negedge clk);
    chk("rolling_hi", 32'(rolling), 1);
    button = 1'b0;
    cnt_m  = cnt_m + 8'd1;
    e.d0  = e0;
    e.d1  = e1;
    e.s   = e0 + e1;
    e.cnt = int'(cnt_m);
    e.dbl = (e0 == e1) ? 1 : 0;
    sbq.push_back(e);
    lat = 0;
    while (lat < 8 && done !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 32'(lat), 2);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'(sbq.size()), 1);
    end else begin
      g = sbq.pop_front();
      chk("die0", 32'(throw[0 +: FW]), 32'(g.d0));
      chk("die1", 32'(throw[FW +: FW]), 32'(g.d1));
      chk("sum", 32'(sum), 32'(g.s));
      chk("roll_cnt", 32'(roll_cnt), 32'(g.cnt));
`ifdef DOUBLES_EN
      chk("doubles", 32'(doubles), 32'(g.dbl));
`endif
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("rolling_lo", 32'(rolling), 0);
  endtask

  // Unheld rolls follow a mixed-radix count: value = (d0-1) + FC*(d1-1).
  task automatic roll_free(input int n);
    v_m = (v_m + n) % (FC * FC);
    roll(n, (v_m % FC) + 1, (v_m / FC) + 1);
  endtask

  initial begin
    rst    = 1'b0;
    button = 1'b0;
    hold   = '0;
    repeat (2) @(negedge clk);
    chk("rst_die0", 32'(throw[0 +: FW]), 1);
    chk("rst_die1", 32'(throw[FW +: FW]), 1);
    chk("rst_sum", 32'(sum), 2);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(roll_cnt), 0);
    chk("rst_rolling", 32'(rolling), 0);
`ifdef DOUBLES_EN
    chk("rst_doubles", 32'(doubles), 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a roll
    button = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rolling", 32'(rolling), 1);
    chk("mid_die0", 32'(throw[0 +: FW]), 4);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_die0", 32'(throw[0 +: FW]), 1);
    chk("mid_rst_die1", 32'(throw[FW +: FW]), 1);
    chk("mid_rst_rolling", 32'(rolling), 0);
    rst    = 1'b1;
    button = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done), 0);
    end
    chk("mid_cnt", 32'(roll_cnt), 0);
    chk("mid_sum", 32'(sum), 2);

    // Short roll to {5,1}, then wrap die0 into {1,2}
    roll_free(4);
    roll_free(2);

    // Reach die0=3, then hold die0 across 8 edges; then hold both
    roll_free(2);
    hold = 2'b01;
    roll(8, 3, 4);
    hold = 2'b11;
    roll(3, 3, 4);
    hold = 2'b00;
    v_m  = 2 + FC * 3;

    // Land on a pair, then a non-pair
    roll_free(23);
    roll_free(5);

    // Run the roll counter past its wrap point
    for (int i = 0; i < 249; i++) begin
      roll_free(1);
    end
    chk("cnt_wrapped", 32'(roll_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
